// File: rtl/pm_pkg.sv
// pm_pkg: shared definitions for the program-memory responder slice.
//   - pm_state_e : responder FSM state encodings (2 bits)
//   - MEM_SIZE   : default program-memory depth in 32-bit words
//   - OP_*       : RV32 major opcodes used to build program images
//   - ALU_OP_*   : ALU operation codes kept alongside the opcodes
//   - mk_i_type  : helper that assembles an I-type instruction word
package pm_pkg;

  typedef enum logic [1:0] {
    PM_IDLE = 2'b00,
    PM_WAIT = 2'b01,
    PM_RESP = 2'b10
  } pm_state_e;

  localparam int MEM_SIZE = 1024;

  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_XOR = 4'd4;
  localparam logic [3:0] ALU_OP_SLL = 4'd5;
  localparam logic [3:0] ALU_OP_SRL = 4'd6;
  localparam logic [3:0] ALU_OP_SRA = 4'd7;

  function automatic logic [31:0] mk_i_type(input logic [11:0] imm,
                                            input logic [4:0]  rs1,
                                            input logic [2:0]  funct3,
                                            input logic [4:0]  rd,
                                            input logic [6:0]  opcode);
    return {imm, rs1, funct3, rd, opcode};
  endfunction

endpackage

// File: rtl/pm_ram.sv
// pm_ram: DEPTH x 32 program-memory array.
//   clock          : rising-edge clock
//   wr_en/wr_idx/wr_data : single word write port
//   rd_en/rd_idx   : read request; data appears on rd_data after the edge
//   rd_data        : registered read data, held until the next rd_en
// A read and a write to the same word in one cycle returns the old word.
module pm_ram
  import pm_pkg::*;
#(
  parameter int DEPTH = MEM_SIZE,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [IW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_reg [DEPTH];
  logic [31:0] rd_data_reg;

  // Both updates are non-blocking, so a same-cycle read sees the pre-write word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_idx];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/prog_mem_responder.sv
// prog_mem_responder: memory side of the CPU32 instruction-fetch interface.
//   clock                 : rising-edge clock
//   reset                 : asynchronous active-low reset (0 = in reset)
//   req_valid/req_addr    : fetch request (byte address), accepted in IDLE
//   req_ready             : high only in IDLE and out of reset
//   rsp_valid/rsp_data/rsp_err : response, held until rsp_ready
//   rsp_ready             : CPU takes the response
//   ld_we/ld_addr/ld_data : word-write load port, usable in any state
// Build option: define PM_ALIGN_CHECK_EN to fault misaligned fetch addresses.
module prog_mem_responder
  import pm_pkg::*;
#(
  parameter int DEPTH   = MEM_SIZE,
  parameter int LATENCY = 1,
  parameter int AW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  input  logic          rsp_ready,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Range checks compare the whole word index, so high address bits never alias.
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  pm_state_e   state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;

  logic [AW-1:0] req_widx, ld_widx;
  logic          req_fault, ld_in_range, accept;
  logic [31:0]   ram_rd_data;

  assign req_widx    = {2'b00, req_addr[AW-1:2]};
  assign ld_widx     = {2'b00, ld_addr[AW-1:2]};
  assign ld_in_range = (ld_widx < DEPTH_W);

`ifdef PM_ALIGN_CHECK_EN
  assign req_fault = (req_widx >= DEPTH_W) || (req_addr[1:0] != 2'b00);
`else
  assign req_fault = (req_widx >= DEPTH_W);
  logic unused_req_lsbs;
  assign unused_req_lsbs = ^req_addr[1:0];
`endif

  // Load addresses are word-granular; the byte offset is discarded.
  logic unused_ld_lsbs;
  assign unused_ld_lsbs = ^ld_addr[1:0];

  assign accept = (state_reg == PM_IDLE) && req_valid;

  // Faulting requests skip the read; their data is forced to zero at the output.
  pm_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ld_we && ld_in_range),
    .wr_idx  (ld_addr[IW+1:2]),
    .wr_data (ld_data),
    .rd_en   (accept && !req_fault),
    .rd_idx  (req_addr[IW+1:2]),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= PM_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      PM_IDLE: begin
        if (req_valid) begin
          err_next = req_fault;
          if (LATENCY == 1) begin
            state_next = PM_RESP;
          end else begin
            cnt_next   = 4'(LATENCY - 1);
            state_next = PM_WAIT;
          end
        end
      end
      PM_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = PM_RESP;
        end
      end
      PM_RESP: begin
        if (rsp_ready) begin
          state_next = PM_IDLE;
        end
      end
      default: begin
        state_next = PM_IDLE;
      end
    endcase
  end

  // req_ready is gated by reset directly so it is low for the whole reset window.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    if (state_reg == PM_IDLE) begin
      req_ready = reset;
    end
    if (state_reg == PM_RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = err_reg;
      rsp_data  = err_reg ? 32'h0 : ram_rd_data;
    end
  end

endmodule
